regfile_write_queue: RTL and testbench

REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

---
 rtl/regfile_write_queue.sv | 132 +++++++++++++
 tb/tb_regfile_write_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue
// Buffers register-file writebacks in a small circular FIFO so producers do
// not stall while the single register-file write port is busy. The head
// entry drives the write port whenever DrainEn allows it, and the Pending
// outputs tell decode that a queued write still targets a register it reads.
// Register 0 is hardwired to zero, so requests aimed at it are acknowledged
// and dropped instead of occupying a slot.

module regfile_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [4:0]               InReg,
  input  logic [31:0]              InData,
  input  logic                     DrainEn,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [31:0]              WriteData,
  input  logic [4:0]               ReadRegister1,
  input  logic [4:0]               ReadRegister2,
  output logic                     Pending1,
  output logic                     Pending2,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCount = CntW'(DEPTH);

  logic [4:0]      regMem  [DEPTH];
  logic [31:0]     dataMem [DEPTH];

  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;
  logic [CntW-1:0] occupancy;

  logic            isFull;
  logic            isEmpty;
  logic            pushEn;
  logic            popEn;

  logic [PtrW-1:0] slotOffset;
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  // Occupancy flags and the push/pop handshakes; a full queue refuses new
  // requests even if the head drains this cycle, which keeps InReady free of
  // any combinational path from DrainEn.
  always_comb begin
    isFull   = (occupancy == DepthCount);
    isEmpty  = (occupancy == '0);
    InReady  = ~isFull;
    RegWrite = DrainEn & ~isEmpty;
    pushEn   = InValid & ~isFull & (InReg != 5'd0);
    popEn    = DrainEn & ~isEmpty;
    Full     = isFull;
    Empty    = isEmpty;
    Count    = occupancy;
  end

  // Head entry goes straight to the write port; zeros when nothing is queued
  // so the register file never sees stale data on an idle cycle.
  always_comb begin
    WriteRegister = 5'd0;
    WriteData     = 32'd0;
    if (!isEmpty) begin
      WriteRegister = regMem[headPtr];
      WriteData     = dataMem[headPtr];
    end
  end

  // Mark which slots currently hold live entries: a slot is live when its
  // distance from the head (modulo DEPTH) is below the occupancy.
  always_comb begin
    slotOffset = '0;
    occupied   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slotOffset  = PtrW'(i) - headPtr;
      occupied[i] = ({1'b0, slotOffset} < occupancy);
    end
  end

  // Hazard lookup against every live entry, including the one draining this
  // cycle; register 0 never reports a pending write.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = occupied[i] & (regMem[i] == ReadRegister1);
      hit2[i] = occupied[i] & (regMem[i] == ReadRegister2);
    end
    Pending1 = (ReadRegister1 != 5'd0) & (|hit1);
    Pending2 = (ReadRegister2 != 5'd0) & (|hit2);
  end

  // Entry storage is not reset; the pointers and occupancy decide validity.
  always_ff @(posedge Clk) begin
    if (pushEn) begin
      regMem[tailPtr]  <= InReg;
      dataMem[tailPtr] <= InData;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets the pointers
  // wrap naturally by overflow.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      occupancy <= '0;
    end else begin
      if (pushEn) begin
        tailPtr <= tailPtr + 1'b1;
      end
      if (popEn) begin
        headPtr <= headPtr + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue
// Drives directed scenarios and a randomized phase into regfile_write_queue
// and compares every output against a queue-based reference model.

module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } entryT;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InReg;
  logic [31:0] InData;
  logic        DrainEn;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Pending1;
  logic        Pending2;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;

  entryT modelQ[$];
  int    checkCount = 0;
  int    failCount = 0;

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk),
    .ResetN(ResetN),
    .InValid(InValid),
    .InReady(InReady),
    .InReg(InReg),
    .InData(InData),
    .DrainEn(DrainEn),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .Pending1(Pending1),
    .Pending2(Pending2),
    .Count(Count),
    .Full(Full),
    .Empty(Empty)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelPending(input logic [4:0] rr);
    logic hit;
    hit = 1'b0;
    if (rr != 5'd0) begin
      foreach (modelQ[i]) begin
        if (modelQ[i].r == rr) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Compare every DUT output against the reference model for the current inputs.
  task automatic checkModel();
    int sz;
    sz = modelQ.size();
    checkOutput("count", 64'(Count), 64'(sz));
    checkOutput("full", 64'(Full), 64'(sz == DEPTH));
    checkOutput("empty", 64'(Empty), 64'(sz == 0));
    checkOutput("inReady", 64'(InReady), 64'(sz != DEPTH));
    checkOutput("regWrite", 64'(RegWrite), 64'(DrainEn && sz > 0));
    checkOutput("writeRegister", 64'(WriteRegister), 64'(sz > 0 ? modelQ[0].r : 5'd0));
    checkOutput("writeData", 64'(WriteData), 64'(sz > 0 ? modelQ[0].d : 32'd0));
    checkOutput("pending1", 64'(Pending1), 64'(modelPending(ReadRegister1)));
    checkOutput("pending2", 64'(Pending2), 64'(modelPending(ReadRegister2)));
  endtask

  // Drive inputs on the falling edge and let combinational outputs settle.
  task automatic driveInputs(input logic valid, input logic [4:0] r, input logic [31:0] d,
                             input logic drain, input logic [4:0] rr1, input logic [4:0] rr2);
    @(negedge Clk);
    InValid       = valid;
    InReg         = r;
    InData        = d;
    DrainEn       = drain;
    ReadRegister1 = rr1;
    ReadRegister2 = rr2;
    #1;
  endtask

  // Advance the model by the transfers the coming rising edge performs.
  task automatic commitEdge();
    logic doPush;
    logic doPop;
    entryT e;
    doPush = InValid && (modelQ.size() < DEPTH) && (InReg != 5'd0);
    doPop  = DrainEn && (modelQ.size() > 0);
    if (doPop) void'(modelQ.pop_front());
    if (doPush) begin
      e.r = InReg;
      e.d = InData;
      modelQ.push_back(e);
    end
    @(posedge Clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] r, input logic [31:0] d,
                               input logic drain, input logic [4:0] rr1, input logic [4:0] rr2);
    driveInputs(valid, r, d, drain, rr1, rr2);
    checkModel();
    commitEdge();
  endtask

  initial begin
    ResetN = 1'b0;
    InValid = 1'b0;
    InReg = 5'd0;
    InData = 32'd0;
    DrainEn = 1'b1;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #2;
    checkOutput("resetEmpty", 64'(Empty), 64'd1);
    checkOutput("resetRegWrite", 64'(RegWrite), 64'd0);
    checkModel();
    @(negedge Clk);
    ResetN = 1'b1;

    // Fill to full with draining disabled, then probe the hazard outputs.
    applyStimulus(1'b1, 5'd3, 32'hAAAA0001, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd7, 32'hBBBB0002, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'hCCCC0003, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd9, 32'h00000004, 1'b0, 5'd0, 5'd0);
    driveInputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd5);
    checkModel();
    checkOutput("fillCount", 64'(Count), 64'd4);
    checkOutput("fillInReady", 64'(InReady), 64'd0);
    checkOutput("fillPending1", 64'(Pending1), 64'd1);
    checkOutput("fillPending2", 64'(Pending2), 64'd0);
    commitEdge();

    // Drain four entries in arrival order.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd7);
    driveInputs(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    checkModel();
    checkOutput("drainedEmpty", 64'(Empty), 64'd1);
    checkOutput("drainedWriteData", 64'(WriteData), 64'd0);
    commitEdge();

    // Requests to register 0 are acknowledged and dropped.
    driveInputs(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0);
    checkOutput("zeroInReady", 64'(InReady), 64'd1);
    commitEdge();
    driveInputs(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    checkOutput("zeroCount", 64'(Count), 64'd0);
    checkOutput("zeroRegWrite", 64'(RegWrite), 64'd0);
    checkModel();
    commitEdge();

    // Streaming push and pop every cycle across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      driveInputs(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'(i), 5'(i + 1));
      checkModel();
      checkOutput("streamCountMax", 64'(Count <= 3'd1), 64'd1);
      checkOutput("streamNotFull", 64'(Full), 64'd0);
      commitEdge();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

    // Full queue with simultaneous request and drain: push refused, then accepted.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(20 + i), 32'(100 + i), 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd30, 32'h30, 1'b1, 5'd30, 5'd20);
    driveInputs(1'b1, 5'd30, 32'h30, 1'b1, 5'd30, 5'd21);
    checkOutput("fullPopCount", 64'(Count), 64'd3);
    checkModel();
    commitEdge();
    driveInputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd30, 5'd0);
    checkOutput("fullRetryCount", 64'(Count), 64'd3);
    checkModel();
    commitEdge();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

    // Asynchronous reset between clock edges with three entries queued.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'(4 + i), 32'(i), 1'b0, 5'd0, 5'd0);
    driveInputs(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd5);
    ResetN = 1'b0;
    #1;
    modelQ.delete();
    checkOutput("asyncCount", 64'(Count), 64'd0);
    checkOutput("asyncRegWrite", 64'(RegWrite), 64'd0);
    checkOutput("asyncPending1", 64'(Pending1), 64'd0);
    checkModel();
    @(posedge Clk);
    @(negedge Clk);
    #1;
    ResetN = 1'b1;
    InValid = 1'b1;
    InReg = 5'd12;
    InData = 32'h12;
    DrainEn = 1'b0;
    #1;
    checkModel();
    commitEdge();
    driveInputs(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0);
    checkOutput("postResetReg", 64'(WriteRegister), 64'd12);
    checkOutput("postResetData", 64'(WriteData), 64'h12);
    checkModel();
    commitEdge();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom(),
                    1'($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
